// File: rtl/duos_arb_if.sv
// duos_arb_if: requester, result and doubler-side signals of the duos_arb arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface duos_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 378
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 drain;
    logic [NUM_REQ-1:0]   res_valid;
    logic [W-1:0]         res_data;
    logic                 dm_valid;
    logic [W-1:0]         dm_in0;
    logic                 dm_valid_out;
    logic [W-1:0]         dm_out;
    logic                 dm_idle;
    logic                 idle;
    logic                 err;

    modport slave (
        input  req_valid, req_data, drain, dm_valid_out, dm_out, dm_idle,
        output req_ready, res_valid, res_data, dm_valid, dm_in0, idle, err
    );

    modport master (
        output req_valid, req_data, drain, dm_valid_out, dm_out, dm_idle,
        input  req_ready, res_valid, res_data, dm_valid, dm_in0, idle, err
    );
endinterface

// File: rtl/duos_arb.sv
// duos_arb: round-robin arbiter sharing one fixed-latency modular doubler among NUM_REQ
// requesters, with a tag pipe that steers results home and per-requester credit limits.
// Optional build macro DUOS_ARB_PRIO0_EN: requester 0 gets strict priority and the
// round-robin pointer only rotates among requesters 1..NUM_REQ-1.
module duos_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 10,
    parameter int unsigned MAX_OUT = 8,
    parameter int unsigned W       = 378
) (
    input  logic       clk,
    input  logic       rst,
    duos_arb_if.slave  bus
);
    localparam int unsigned IdW    = $clog2(NUM_REQ);
    localparam int unsigned MaskW  = $clog2(LATENCY + 2);
    localparam logic [3:0]  MaxOut = 4'(MAX_OUT);

    logic [IdW-1:0]     r_ptr;
    logic [3:0]         r_cnt [NUM_REQ];
    logic [LATENCY:0]   r_tag_v;
    logic [IdW-1:0]     r_tag_id [LATENCY+1];
    logic               r_dm_valid;
    logic [W-1:0]       r_dm_in0;
    logic [NUM_REQ-1:0] r_res_valid;
    logic [W-1:0]       r_res_data;
    logic               r_err;
    logic [MaskW-1:0]   r_mask;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_dec;
    logic               w_found;
    logic               w_ptr_upd;
    logic [IdW-1:0]     w_gidx;
    logic [IdW-1:0]     w_cand;
    logic               w_tag_out_v;
    logic [IdW-1:0]     w_tag_out_id;
    logic               w_hit;
    logic               w_cnt_zero;
    logic               w_res_ok;
    logic               w_bad;
    logic               w_all_zero;

    // Eligibility: valid, below credit limit, not draining.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] & (r_cnt[i] < MaxOut) & ~bus.drain;
        end
    end

    // Grant search starting just after the last winner.
    always_comb begin
        w_found   = 1'b0;
        w_gidx    = '0;
        w_cand    = '0;
        w_ptr_upd = 1'b0;
`ifdef DUOS_ARB_PRIO0_EN
        if (w_elig[0]) begin
            w_found = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
            w_cand = IdW'(((32'(r_ptr) + k) % (NUM_REQ - 1)) + 1);
            if (!w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gidx    = w_cand;
                w_ptr_upd = 1'b1;
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IdW'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_cand]) begin
                w_found   = 1'b1;
                w_gidx    = w_cand;
                w_ptr_upd = 1'b1;
            end
        end
`endif
        w_grant = '0;
        if (w_found) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    // Result qualification against the tag leaving the pipe.
    always_comb begin
        w_tag_out_v  = r_tag_v[LATENCY];
        w_tag_out_id = r_tag_id[LATENCY];
        w_hit        = w_tag_out_v & bus.dm_valid_out;
        w_cnt_zero   = (r_cnt[w_tag_out_id] == 4'd0);
        w_res_ok     = w_hit & ~w_cnt_zero;
        w_bad        = (w_tag_out_v ^ bus.dm_valid_out) | (w_hit & w_cnt_zero);
        w_dec        = '0;
        if (w_res_ok) begin
            w_dec[w_tag_out_id] = 1'b1;
        end
        w_all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_cnt[i] != 4'd0) begin
                w_all_zero = 1'b0;
            end
        end
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IdW'(NUM_REQ - 1);
            r_dm_valid <= 1'b0;
            r_dm_in0   <= '0;
        end else begin
            r_dm_valid <= w_found;
            if (w_found) begin
                r_dm_in0 <= bus.req_data[32'(w_gidx) * W +: W];
            end
            if (w_ptr_upd) begin
                r_ptr <= w_gidx;
            end
        end
    end

    // Tag pipe: stage 0 loads with dm_valid, last stage lines up with dm_valid_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[LATENCY-1:0], w_found};
            r_tag_id[0] <= w_gidx;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Credit counters; simultaneous accept and result cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_cnt[i] <= 4'd0;
            end else if (w_grant[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + 4'd1;
            end else if (w_dec[i] && !w_grant[i]) begin
                r_cnt[i] <= r_cnt[i] - 4'd1;
            end
        end
    end

    // Result steering and sticky error; stale post-reset results are masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
            r_mask      <= MaskW'(LATENCY + 1);
        end else begin
            r_res_valid <= w_dec;
            if (w_res_ok) begin
                r_res_data <= bus.dm_out;
            end
            if (w_bad && (r_mask == '0)) begin
                r_err <= 1'b1;
            end
            if (r_mask != '0) begin
                r_mask <= r_mask - MaskW'(1);
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.dm_valid  = r_dm_valid;
    assign bus.dm_in0    = r_dm_in0;
    assign bus.err       = r_err;
    assign bus.idle      = bus.dm_idle & ~(|r_tag_v) & ~r_dm_valid & w_all_zero
                           & ~(|bus.req_valid);
endmodule
